// File: rtl/fir_decim_ctrl_pkg.sv
// fir_decim_ctrl_pkg: state encoding and address helpers shared by the decimator controller
package fir_decim_ctrl_pkg;
  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, RUN = 2'd2} state_t;
  function automatic int addr_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
  function automatic int unsigned mod_dec(input int unsigned a, input int unsigned b, input int unsigned m);
    return (a >= b) ? a - b : a + m - b;
  endfunction
endpackage

// File: rtl/fir_decim_ctrl_if.sv
// fir_decim_ctrl_if: sample stream, delay-line RAM, coefficient ROM and MAC strobes
interface fir_decim_ctrl_if import fir_decim_ctrl_pkg::*; #(parameter int N = 8, parameter int M = 32);
  localparam int AW = addr_w(M);
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [N-1:0]  ram_wr_din;
  logic [AW-1:0] ram_rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_last;
  modport master (
    input  in_valid, in_data,
    output in_ready, ram_en, ram_we, ram_wr_addr, ram_wr_din, ram_rd_addr, coef_addr,
           mac_clr, mac_en, mac_last
  );
  modport slave (
    output in_valid, in_data,
    input  in_ready, ram_en, ram_we, ram_wr_addr, ram_wr_din, ram_rd_addr, coef_addr,
           mac_clr, mac_en, mac_last
  );
endinterface

// File: rtl/fir_decim_tap_seq.sv
// fir_decim_tap_seq: tap sweep newest-to-oldest and the one-stage MAC strobe pipe
module fir_decim_tap_seq import fir_decim_ctrl_pkg::*; #(
  parameter int M = 32,
  localparam int AW = addr_w(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  input  logic [AW-1:0] base_in,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] k,
  output logic          done,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last
);
  logic [AW-1:0] base;
  assign done = run && k == AW'(M - 1);
  assign rd_addr = AW'(mod_dec(32'(base), 32'(k), 32'(M)));
  // strobes trail the read address by one cycle to line up with RAM/ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      base <= '0;
      mac_clr <= 1'b0;
      mac_en <= 1'b0;
      mac_last <= 1'b0;
    end else begin
      if (start) begin
        base <= base_in;
        k <= '0;
      end else if (run) begin
        k <= done ? '0 : k + 1'b1;
      end
      mac_en <= run;
      mac_clr <= run && k == '0;
      mac_last <= done;
    end
  end
endmodule

// File: rtl/fir_decim_ctrl.sv
// fir_decim_ctrl: circular delay-line writer, decimation phase counter and frame FSM
module fir_decim_ctrl import fir_decim_ctrl_pkg::*; #(
  parameter int N = 8,
  parameter int M = 32,
  parameter int D = 4
) (
  input logic clk,
  input logic rst,
  fir_decim_ctrl_if.master bus
);
  localparam int AW = addr_w(M);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  state_t state, state_nx;
  logic [AW-1:0] wp, wp_nx, rd_addr, k;
  logic [PW-1:0] phase, phase_nx;
  logic hs, start, run, done, wr, mac_clr, mac_en, mac_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      wp <= '0;
      phase <= '0;
    end else begin
      state <= state_nx;
      wp <= wp_nx;
      phase <= phase_nx;
    end
  end
  // wp doubles as the zero-fill address during CLEAR and ends back at 0
  always_comb begin
    hs = state == IDLE && bus.in_valid;
    run = state == RUN;
    wr = state == CLEAR || hs;
    start = hs && phase == PW'(D - 1);
    wp_nx = wr ? (wp == AW'(M - 1) ? '0 : wp + 1'b1) : wp;
    phase_nx = hs ? (start ? '0 : phase + 1'b1) : phase;
    state_nx = (state == CLEAR && wp == AW'(M - 1)) ? IDLE :
               start ? RUN :
               (run && done) ? IDLE : state;
  end
  fir_decim_tap_seq #(.M(M)) u_seq (
    .clk(clk), .rst(rst), .start(start), .run(run), .base_in(wp),
    .rd_addr(rd_addr), .k(k), .done(done),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last)
  );
  assign bus.in_ready = !rst && state == IDLE;
  assign bus.ram_en = !rst && (wr || run);
  assign bus.ram_we = !rst && wr;
  assign bus.ram_wr_addr = (!rst && wr) ? wp : '0;
  assign bus.ram_wr_din = (!rst && hs) ? bus.in_data : N'(0);
  assign bus.ram_rd_addr = (!rst && run) ? rd_addr : '0;
  assign bus.coef_addr = (!rst && run) ? k : '0;
  assign bus.mac_clr = !rst && mac_clr;
  assign bus.mac_en = !rst && mac_en;
  assign bus.mac_last = !rst && mac_last;
endmodule

// File: tb/tb_fir_decim_ctrl.sv
// tb_fir_decim_ctrl: vector table plus scoreboard for writes, tap reads and MAC strobes
module tb_fir_decim_ctrl;
  typedef struct {logic [7:0] din; logic [2:0] waddr; bit trig; logic [2:0] base;} vec_t;
  typedef struct {logic [2:0] addr; logic [7:0] din;} wr_t;
  typedef struct {int cyc; logic [2:0] rd; logic [2:0] coef;} rd_t;
  typedef struct {int cyc; logic clr; logic last;} mac_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  wr_t wq[$];
  rd_t rq[$];
  mac_t mq[$];
  vec_t vt[12];
  fir_decim_ctrl_if #(.N(8), .M(8)) bus();
  fir_decim_ctrl #(.N(8), .M(8), .D(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.ram_we) begin
      wr_t w;
      chk("wr_en", bus.ram_en, 1);
      if (wq.size() == 0) miss("ram_write");
      else begin
        w = wq.pop_front();
        chk("wr_addr", bus.ram_wr_addr, w.addr);
        chk("wr_din", bus.ram_wr_din, w.din);
      end
    end
    if (bus.ram_en && !bus.ram_we) begin
      rd_t r;
      if (rq.size() == 0) miss("ram_read");
      else begin
        r = rq.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_addr", bus.ram_rd_addr, r.rd);
        chk("coef_addr", bus.coef_addr, r.coef);
      end
    end
    if (bus.mac_en) begin
      mac_t m;
      if (mq.size() == 0) miss("mac_en");
      else begin
        m = mq.pop_front();
        chk("mac_cycle", cyc, m.cyc);
        chk("mac_clr", bus.mac_clr, m.clr);
        chk("mac_last", bus.mac_last, m.last);
      end
    end else if (bus.mac_clr || bus.mac_last) miss("mac_clr_last_without_en");
  end

  task automatic push_frame(input int t, input int base);
    for (int k = 0; k < 8; k++) begin
      rq.push_back('{t + 1 + k, 3'((base - k + 8) % 8), 3'(k)});
      mq.push_back('{t + 2 + k, k == 0, k == 7});
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < 8; i++) wq.push_back('{3'(i), 8'h00});
  endtask

  task automatic send(input logic [7:0] d, output int t);
    int n = 0;
    int st = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    while (!bus.in_ready && n < 50) begin
      if (bus.ram_we && bus.ram_wr_din == d) st++;
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", n < 50, 1);
    chk("no_write_while_stalled", st, 0);
    t = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  initial begin
    int t, t_trig, t_bp, n;
    vt = '{'{8'd1, 3'd0, 1'b0, 3'd0}, '{8'd2, 3'd1, 1'b0, 3'd0}, '{8'd3, 3'd2, 1'b0, 3'd0},
           '{8'd4, 3'd3, 1'b1, 3'd3}, '{8'd5, 3'd4, 1'b0, 3'd0}, '{8'd6, 3'd5, 1'b0, 3'd0},
           '{8'd7, 3'd6, 1'b0, 3'd0}, '{8'd8, 3'd7, 1'b1, 3'd7}, '{8'd9, 3'd0, 1'b0, 3'd0},
           '{8'd10, 3'd1, 1'b0, 3'd0}, '{8'd11, 3'd2, 1'b0, 3'd0}, '{8'd12, 3'd3, 1'b1, 3'd3}};
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ram_en", bus.ram_en, 0);
    end
    push_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("clear_in_ready", bus.in_ready, i == 9);
      chk("clear_we", bus.ram_we, i <= 8);
    end
    t_trig = 0;
    for (int i = 0; i < 12; i++) begin
      wq.push_back('{vt[i].waddr, vt[i].din});
      send(vt[i].din, t);
      if (vt[i].trig) begin
        push_frame(t, vt[i].base);
        t_trig = t;
      end
    end
    wq.push_back('{3'd4, 8'h55});
    send(8'h55, t_bp);
    chk("bp_accept_cycle", t_bp, t_trig + 9);
    for (int i = 0; i < 3; i++) begin
      wq.push_back('{3'(5 + i), 8'(8'h61 + i)});
      send(8'(8'h61 + i), t);
    end
    push_frame(t, 7);
    while (cyc != t + 4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    rq.delete();
    mq.delete();
    push_clear();
    @(negedge clk);
    chk("abort_rst_mac_en", bus.mac_en, 0);
    chk("abort_rst_mac_last", bus.mac_last, 0);
    chk("abort_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mac_en", bus.mac_en, 0);
    chk("abort_mac_last", bus.mac_last, 0);
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{3'(i), 8'(8'h70 + i)});
      send(8'(8'h70 + i), t);
      if (i == 3) push_frame(t, 3);
      else repeat (2) begin
        @(negedge clk);
        chk("gap_in_ready", bus.in_ready, 1);
      end
    end
    n = 0;
    while ((rq.size() + mq.size() + wq.size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", rq.size() + mq.size() + wq.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_decim_ctrl.md
Name: fir_decim_ctrl

Overview:
Sequencing controller for the polyphase lowpass decimator's sample delay line, which is held in the 1-read/1-write dual-port RAM. It writes accepted input samples into a circular buffer and counts decimation phase. Every D-th sample it sweeps all M taps newest-to-oldest, driving RAM read addresses, coefficient addresses and MAC strobes. Sits between the input sample stream and the RAM, coefficient ROM and MAC.

Parameters:
N, 8, sample width in bits
M, 32, taps = RAM depth (M >= 2, need not be a power of 2)
D, 4, decimation factor (D >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_data  in  N  input sample
in_ready  out  1  controller accepts the sample this cycle
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_wr_addr  out  $clog2(M)  RAM write address
ram_wr_din  out  N  RAM write data
ram_rd_addr  out  $clog2(M)  RAM read address
coef_addr  out  $clog2(M)  coefficient ROM address (tap index k), 1-cycle read latency, same as RAM
mac_clr  out  1  high with the first valid RAM/ROM data of a frame (load, not accumulate)
mac_en  out  1  RAM/ROM read data valid, accumulate
mac_last  out  1  high with the last product of a frame

Behaviour:
- Reset: synchronous, active-high. Sets state=CLEAR, wp=0, phase=0, k=0 and the mac pipe to 0. While rst is high, all outputs are 0 and in_ready=0.
- Reset wins over every other event. Reset mid-RUN aborts the frame: mac_en, mac_clr and mac_last are 0 from the cycle after rst rises, and the aborted frame never gets mac_last.
- States are CLEAR, IDLE and RUN.
- CLEAR: lasts M cycles after rst deasserts, with ram_en=ram_we=1, ram_wr_addr=0..M-1 and ram_wr_din=0. in_ready=0. Moves to IDLE after address M-1.
- IDLE: in_ready=1. A handshake is in_valid&in_ready.
  - On handshake: ram_en=ram_we=1, ram_wr_addr=wp, ram_wr_din=in_data, then wp <= (wp==M-1)?0:wp+1.
  - If phase==D-1: phase <= 0, base <= wp (the newest sample's address), k <= 0, state <= RUN. Otherwise phase <= phase+1.
  - Without a handshake, ram_we=0 and nothing changes.
- RUN: in_ready=0, ram_we=0, ram_en=1.
  - ram_rd_addr = (base-k) mod M, with explicit wrap (base<k gives base-k+M).
  - coef_addr = k.
  - k increments each cycle. After k=M-1 the state returns to IDLE, so RUN lasts exactly M cycles.
  - RAM read-after-write is safe: the triggering write commits on the edge before the first read.
- MAC pipe: the read strobe is registered once, so mac_en is high for cycles t+2..t+M+1, where t is the triggering handshake cycle.
  - mac_clr goes with the k=0 data; mac_last goes with the k=M-1 data.
  - For M taps, frame latency from trigger to mac_last is M+1 cycles.
  - in_ready returns at t+M+1. A write then cannot corrupt the in-flight last read, which was captured at the end of t+M.
- D==1: every accepted sample triggers RUN.
- phase advances only on handshakes. Gaps in in_valid and stalls while in_ready=0 do not advance it.
- in_data must be held by the source while in_valid=1 and in_ready=0.

Decomposition:
- Shared package/include holds:
  - the state encoding (CLEAR, IDLE, RUN);
  - the address-width function ADDR_W=$clog2(M);
  - the modular-decrement helper.
- One natural sub-module, fir_decim_tap_seq: owns k, base-relative read address, coef_addr, and the 1-stage mac_en/clr/last delay pipe.
- fir_decim_ctrl keeps the FSM, wp and phase.

Test Plan:
All scenarios use N=8, M=8, D=4.

1. Reset: rst high 2 cycles then low.
   - Expect in_ready=0 during reset.
   - Expect 8 cycles of ram_we=1 to addresses 0..7 with din=0.
   - Expect in_ready=1 on the 9th cycle after release.
2. First frame: samples 1,2,3,4 back-to-back.
   - Expect writes to addresses 0..3.
   - Expect 8 cycles with in_ready=0, ram_rd_addr 3,2,1,0,7,6,5,4 and coef_addr 0..7.
   - Expect mac_en high 8 cycles starting 2 cycles after sample 4, mac_clr on the first, mac_last on the last.
3. Wrap: continue to 12 samples.
   - Frame 2 base=7 gives rd 7..0.
   - Frame 3 base=3 (wp wraps 7->0) gives rd 3,2,1,0,7,6,5,4 again.
4. Backpressure: in_valid=1, in_data=0x55 held through RUN.
   - Expect no write during RUN.
   - Expect 0x55 written at wp on the first IDLE cycle, and phase=1 afterwards.
5. Reset mid-RUN at k=3.
   - Expect mac_en=0 the next cycle and no mac_last.
   - Expect CLEAR restarted, wp=0 and phase=0.
   - Expect the next frame to trigger only after 4 new samples.
6. Gapped input: in_valid high 1 cycle in 3.
   - Expect RUN to start only after the 4th accepted sample.
   - Expect the rd_addr sequence identical to scenario 2.
